// File: rtl/qkd_key_engine.sv
// BB84-style QKD key engine: twin LFSR photon source, basis sifting, error count.
// Optional QKD_QBER_ABORT_EN aborts completion when errors exceed QBER_THR.
`timescale 1ns/1ps
module qkd_key_engine #(
  parameter int          KEY_W       = 16,
  parameter logic [15:0] SEED_A      = 16'hACE1,
  parameter logic [15:0] SEED_B      = 16'h1D2B,
  parameter int          MAX_PHOTONS = 1024,
  parameter int          ERR_PERIOD  = 8,
  parameter int          QBER_THR    = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             flip_en,
  input  logic                             key_ready,
  output logic                             busy,
  output logic                             key_valid,
  output logic                             abort,
  output logic [KEY_W-1:0]                 final_key,
  output logic [$clog2(KEY_W+1)-1:0]       sifted_cnt,
  output logic [$clog2(KEY_W+1)-1:0]       err_cnt,
  output logic [$clog2(MAX_PHOTONS+1)-1:0] photon_cnt
);

  localparam int CW = $clog2(KEY_W+1);
  localparam int PW = $clog2(MAX_PHOTONS+1);
  localparam int EW = $clog2(ERR_PERIOD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_ABORT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [15:0]      r_lfsr_a;
  logic [15:0]      r_lfsr_b;
  logic [KEY_W-1:0] r_key;
  logic [CW-1:0]    r_sifted;
  logic [CW-1:0]    r_err;
  logic [PW-1:0]    r_photon;

  logic          w_fb_a;
  logic          w_fb_b;
  logic          w_a_bit;
  logic          w_b_bit;
  logic          w_inj;
  logic          w_match;
  logic          w_err;
  logic          w_last;
  logic          w_budget;
  logic          w_qber_fail;
  logic          w_run;
  logic          w_clear;
  logic [CW-1:0] w_err_nxt;

  assign w_fb_a = r_lfsr_a[15] ^ r_lfsr_a[13]
                ^ r_lfsr_a[12] ^ r_lfsr_a[10];
  assign w_fb_b = r_lfsr_b[15] ^ r_lfsr_b[13]
                ^ r_lfsr_b[12] ^ r_lfsr_b[10];

  // Injection hits the last photon index of each ERR_PERIOD window
  assign w_inj   = flip_en & (&r_photon[EW-1:0]);
  assign w_a_bit = r_lfsr_a[0];
  assign w_b_bit = w_a_bit ^ w_inj;
  assign w_match = (r_lfsr_a[1] == r_lfsr_b[1]);
  assign w_err   = w_match & (w_a_bit != w_b_bit);

  assign w_last   = w_match && (r_sifted == CW'(KEY_W-1));
  assign w_budget = (r_photon >= PW'(MAX_PHOTONS-1));

  assign w_err_nxt = (w_err && (r_err != CW'(KEY_W)))
                   ? r_err + CW'(1) : r_err;

`ifdef QKD_QBER_ABORT_EN
  assign w_qber_fail = (int'(w_err_nxt) > QBER_THR);
`else
  assign w_qber_fail = 1'b0;
`endif

  assign w_run   = (r_state == S_RUN);
  assign w_clear = start &&
                   ((r_state == S_IDLE) || (r_state == S_ABORT));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_ABORT: begin
        if (start) w_next = S_RUN;
      end
      S_RUN: begin
        if (w_last)
          w_next = w_qber_fail ? S_ABORT : S_DONE;
        else if (w_budget)
          w_next = S_ABORT;
      end
      S_DONE: begin
        if (key_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_lfsr_a <= SEED_A;
      r_lfsr_b <= SEED_B;
      r_key    <= '0;
      r_sifted <= '0;
      r_err    <= '0;
      r_photon <= '0;
    end else begin
      r_state <= w_next;
      if (w_run) begin
        r_lfsr_a <= {r_lfsr_a[14:0], w_fb_a};
        r_lfsr_b <= {r_lfsr_b[14:0], w_fb_b};
        if (r_photon != PW'(MAX_PHOTONS))
          r_photon <= r_photon + PW'(1);
        if (w_match) begin
          r_key <= {r_key[KEY_W-2:0], w_a_bit};
          if (r_sifted != CW'(KEY_W))
            r_sifted <= r_sifted + CW'(1);
        end
        r_err <= w_err_nxt;
      end else if (w_clear) begin
        r_key    <= '0;
        r_sifted <= '0;
        r_err    <= '0;
        r_photon <= '0;
      end
    end
  end

  assign busy       = (r_state == S_RUN);
  assign key_valid  = (r_state == S_DONE);
  assign abort      = (r_state == S_ABORT);
  assign final_key  = r_key;
  assign sifted_cnt = r_sifted;
  assign err_cnt    = r_err;
  assign photon_cnt = r_photon;

endmodule

// File: tb/tb_qkd_key_engine.sv
// Directed bench for qkd_key_engine: equal-seed key, error injection,
// photon budget abort, DONE hold and asynchronous reset.
`timescale 1ns/1ps
module tb_qkd_key_engine;

  logic clk;
  logic rst;

  logic        s0_start, s0_flip, s0_ready;
  logic        s0_busy, s0_kv, s0_abort;
  logic [15:0] s0_key;
  logic [4:0]  s0_sift, s0_err;
  logic [10:0] s0_ph;

  logic        s1_start, s1_flip, s1_ready;
  logic        s1_busy, s1_kv, s1_abort;
  logic [63:0] s1_key;
  logic [6:0]  s1_sift, s1_err;
  logic [3:0]  s1_ph;

  int tests;
  int fails;

  qkd_key_engine #(
    .KEY_W(16), .SEED_A(16'hACE1), .SEED_B(16'hACE1),
    .MAX_PHOTONS(1024), .ERR_PERIOD(4), .QBER_THR(3)
  ) dut0 (
    .clk(clk), .rst(rst), .start(s0_start),
    .flip_en(s0_flip), .key_ready(s0_ready),
    .busy(s0_busy), .key_valid(s0_kv), .abort(s0_abort),
    .final_key(s0_key), .sifted_cnt(s0_sift),
    .err_cnt(s0_err), .photon_cnt(s0_ph)
  );

  qkd_key_engine #(
    .KEY_W(64), .MAX_PHOTONS(8)
  ) dut1 (
    .clk(clk), .rst(rst), .start(s1_start),
    .flip_en(s1_flip), .key_ready(s1_ready),
    .busy(s1_busy), .key_valid(s1_kv), .abort(s1_abort),
    .final_key(s1_key), .sifted_cnt(s1_sift),
    .err_cnt(s1_err), .photon_cnt(s1_ph)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    s0_start = 0; s0_flip = 0; s0_ready = 0;
    s1_start = 0; s1_flip = 0; s1_ready = 0;
    #1;
    chk("rst_busy", s0_busy, 0);
    chk("rst_kv", s0_kv, 0);
    chk("rst_abort", s0_abort, 0);
    chk("rst_key", s0_key, 0);
    chk("rst_ph", s0_ph, 0);
    chk("rst_key1", s1_key, 0);
    chk("rst_sift1", s1_sift, 0);
    tick(2);
    #2 rst = 1'b0;
    tick(1);

    // Run 1: equal seeds, no injection
    s0_start = 1; tick(1); s0_start = 0;
    chk("r1_busy", s0_busy, 1);
    chk("r1_ph0", s0_ph, 0);
    tick(15);
    chk("r1_c16_kv", s0_kv, 0);
    chk("r1_c16_sift", s0_sift, 15);
    tick(1);
    chk("r1_kv", s0_kv, 1);
    chk("r1_busy_off", s0_busy, 0);
    chk("r1_key", s0_key, 16'hF22A);
    chk("r1_sift", s0_sift, 16);
    chk("r1_ph", s0_ph, 16);
    chk("r1_err", s0_err, 0);

    for (int i = 0; i < 10; i++) begin
      s0_start = i[0];
      tick(1);
      chk("hold_kv", s0_kv, 1);
      chk("hold_key", s0_key, 16'hF22A);
    end
    s0_start = 0;
    chk("hold_ph", s0_ph, 16);
    s0_ready = 1; tick(1); s0_ready = 0;
    chk("rel_kv", s0_kv, 0);
    chk("rel_busy", s0_busy, 0);
    chk("idle_key", s0_key, 16'hF22A);

    // Run 2: error injection on photons 3,7,11,15
    s0_flip = 1;
    s0_start = 1; tick(1); s0_start = 0;
    chk("r2_clr_key", s0_key, 0);
    tick(3);
    chk("r2_err_c4", s0_err, 0);
    tick(1);
    chk("r2_err_c5", s0_err, 1);
    tick(12);
    chk("r2_err", s0_err, 4);
    chk("r2_sift", s0_sift, 16);
`ifdef QKD_QBER_ABORT_EN
    chk("r2_abort", s0_abort, 1);
    chk("r2_kv", s0_kv, 0);
`else
    chk("r2_abort", s0_abort, 0);
    chk("r2_kv", s0_kv, 1);
`endif
    s0_ready = 1; tick(1); s0_ready = 0;
    s0_flip = 0;

    // Asynchronous reset mid-RUN
    s0_start = 1; tick(1); s0_start = 0;
    tick(4);
    chk("mid_busy_pre", s0_busy, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", s0_busy, 0);
    chk("arst_ph", s0_ph, 0);
    chk("arst_key", s0_key, 0);
    chk("arst_sift", s0_sift, 0);
    #2 rst = 1'b0;
    tick(1);
    s0_start = 1; tick(1); s0_start = 0;
    tick(16);
    chk("r3_kv", s0_kv, 1);
    chk("r3_key", s0_key, 16'hF22A);
    chk("r3_ph", s0_ph, 16);
    s0_ready = 1; tick(1); s0_ready = 0;

    // Photon budget abort on dut1
    s1_start = 1; tick(1); s1_start = 0;
    chk("b_busy", s1_busy, 1);
    tick(7);
    chk("b_c8_abort", s1_abort, 0);
    chk("b_c8_ph", s1_ph, 7);
    tick(1);
    chk("b_abort", s1_abort, 1);
    chk("b_busy_off", s1_busy, 0);
    chk("b_ph", s1_ph, 8);
    chk("b_kv", s1_kv, 0);
    tick(3);
    chk("b_hold_ph", s1_ph, 8);
    chk("b_err", s1_err, 0);
    s1_start = 1; tick(1); s1_start = 0;
    chk("b_re_abort", s1_abort, 0);
    chk("b_re_busy", s1_busy, 1);
    chk("b_re_ph", s1_ph, 0);
    tick(8);
    chk("b_re_abort2", s1_abort, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/qkd_key_engine.md
QKD_KEY_ENGINE -- requirements
Module: qkd_key_engine

Interface
REQ-001 Parameter KEY_W, default 16: final key length in bits, range 2..256.
REQ-002 Parameter SEED_A, default 16'hACE1: Alice 16-bit LFSR reset seed, nonzero.
REQ-003 Parameter SEED_B, default 16'h1D2B: Bob 16-bit LFSR reset seed, nonzero.
REQ-004 Parameter MAX_PHOTONS, default 1024: photon budget per run before timeout.
REQ-005 Parameter ERR_PERIOD, default 8: error-injection period, power of two, 2 or more.
REQ-006 Parameter QBER_THR, default 2: maximum tolerated sifted-bit mismatches.
REQ-007 clk  in  1  single clock, rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 start  in  1  run request, sampled in IDLE and ABORT only.
REQ-010 flip_en  in  1  enables channel-error injection on Bob's measured bit.
REQ-011 key_ready  in  1  consumer accepts the key.
REQ-012 busy  out  1  high in RUN.
REQ-013 key_valid  out  1  high in DONE.
REQ-014 abort  out  1  high in ABORT.
REQ-015 final_key  out  KEY_W  Alice sifted key.
REQ-016 sifted_cnt  out  $clog2(KEY_W+1)  sifted bits this run.
REQ-017 err_cnt  out  $clog2(KEY_W+1)  Alice/Bob mismatches among sifted bits.
REQ-018 photon_cnt  out  $clog2(MAX_PHOTONS+1)  photons this run.

Function
REQ-019 Both LFSRs: shift left, feedback bit = q[15]^q[13]^q[12]^q[10] inserted at q[0], advance once per RUN cycle only.
REQ-020 Per photon: Alice bit = lfsr_a[0], Alice basis = lfsr_a[1], Bob basis = lfsr_b[1], all taken before the advance.
REQ-021 Bob bit = Alice bit, inverted when flip_en=1 and the photon index (photon_cnt before increment) mod ERR_PERIOD = ERR_PERIOD-1.
REQ-022 FSM states: IDLE, RUN, DONE, ABORT.
REQ-023 IDLE or ABORT with start=1 -> RUN next cycle; clears photon_cnt, sifted_cnt, err_cnt, final_key and abort; LFSRs keep their state.
REQ-024 Each RUN cycle: photon_cnt+1; on basis match, final_key <= {final_key[KEY_W-2:0], Alice bit}, sifted_cnt+1, and err_cnt+1 if the bits differ.
REQ-025 The RUN cycle producing sift number KEY_W -> DONE next cycle; key_valid is first high one cycle after the last sift.
REQ-026 RUN with photon_cnt reaching MAX_PHOTONS before KEY_W sifts -> ABORT; if the final sift and budget exhaustion coincide, completion wins.
REQ-027 DONE holds key_valid, final_key and all counters stable until key_valid&key_ready; then -> IDLE next cycle.
REQ-028 start is ignored in RUN and DONE.
REQ-029 Counters saturate, never wrap; final_key unchanged outside RUN.

Reset
REQ-030 rst=1 immediately forces IDLE, lfsr_a=SEED_A, lfsr_b=SEED_B, all outputs 0, regardless of clock, including mid-RUN or in DONE.
REQ-031 After rst release, the first start behaves as a normal IDLE start.

Configuration
REQ-032 Macro QKD_QBER_ABORT_EN defined: at the completion cycle of REQ-025, err_cnt > QBER_THR -> ABORT instead of DONE; key_valid stays 0.
REQ-033 Macro QKD_QBER_ABORT_EN undefined: completion always -> DONE; err_cnt is informational only.

Verification
REQ-034 SEED_A=SEED_B, KEY_W=16, flip_en=0, start pulsed at cycle 0 -> key_valid=1 at cycle 17, sifted_cnt=16, photon_cnt=16, err_cnt=0, final_key = first 16 Alice bits, first bit at MSB.
REQ-035 Same setup, flip_en=1, ERR_PERIOD=4 -> err_cnt=4 (photons 3, 7, 11, 15); with QKD_QBER_ABORT_EN and QBER_THR=3 -> abort=1 at cycle 17, key_valid=0; without the macro -> key_valid=1.
REQ-036 Default seeds, MAX_PHOTONS=8, KEY_W=64 -> abort=1 after 8 RUN cycles, photon_cnt=8; a new start clears abort and re-enters RUN.
REQ-037 key_ready held 0 for 10 cycles in DONE, with start pulses -> key_valid and final_key stable; key_ready=1 -> IDLE next cycle.
REQ-038 rst asserted mid-RUN between clock edges -> outputs 0 immediately; a rerun with equal seeds reproduces the REQ-034 key.
